savestate_sequencer: RTL and testbench

- Sits between the savestate UI (save/load pulses, selected slot) and the savestate engine (state serializer to SDRAM/DDR).
- Arbitrates save/load requests and holds at most one pending request while busy.
- Synchronises each operation to a frame boundary, pauses the core, and hands off to the engine.
- Tracks which slots hold a valid state and emits OSD info codes for success, timeout and empty-slot errors.

---
 rtl/savestate_pkg.sv | 29 ++
 rtl/savestate_sequencer_if.sv | 43 ++++
 rtl/savestate_sequencer.sv | 131 +++++++++++++
 tb/tb_savestate_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/savestate_pkg.sv
// Shared types and info codes for the savestate sequencer.
package savestate_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SYNC,
    PAUSE,
    START,
    RUN,
    RESUME,
    REPORT
  } state_t;

  localparam logic [7:0] INFO_OK_BASE = 8'd10;
  localparam logic [7:0] INFO_TIMEOUT = 8'd18;
  localparam logic [7:0] INFO_EMPTY   = 8'd19;

  typedef struct packed {
    logic       valid;
    logic       load;
    logic [1:0] slot;
  } pend_t;

  // Success code packs {slot, load} above the base, covering 10..17.
  function automatic logic [7:0] ok_code(input logic [1:0] slot, input logic load);
    return INFO_OK_BASE + {5'd0, slot, load};
  endfunction

endpackage

// File: rtl/savestate_sequencer_if.sv
// Signal bundle between UI/core/engine (master side) and the sequencer (slave side).
interface savestate_sequencer_if #(
  parameter int SLOTS = 4
);
  import savestate_pkg::*;

  // Handshakes: req_save/req_load and eng_done/eng_start/info_req are single-cycle
  // pulses with no back-pressure; pause_req/pause_ack is a level four-phase pair
  // (raise req, wait ack high, drop req, wait ack low).
  logic             req_save;
  logic             req_load;
  logic [1:0]       req_slot;
  logic             vblank;
  logic             pause_ack;
  logic             eng_done;
  logic [SLOTS-1:0] slot_valid_init;
  logic             init_stb;

  logic             pause_req;
  logic             eng_start;
  logic             eng_load;
  logic [1:0]       eng_slot;
  logic             busy;
  logic [SLOTS-1:0] slot_valid;
  logic             info_req;
  logic [7:0]       info;
  state_t           dbg_state;

  modport master (
    output req_save, req_load, req_slot, vblank, pause_ack, eng_done,
           slot_valid_init, init_stb,
    input  pause_req, eng_start, eng_load, eng_slot, busy, slot_valid,
           info_req, info, dbg_state
  );

  modport slave (
    input  req_save, req_load, req_slot, vblank, pause_ack, eng_done,
           slot_valid_init, init_stb,
    output pause_req, eng_start, eng_load, eng_slot, busy, slot_valid,
           info_req, info, dbg_state
  );

endinterface

// File: rtl/savestate_sequencer.sv
// Frame-synchronised save/load sequencer: pauses the core on a vblank edge,
// runs the savestate engine under a watchdog and reports the outcome to the OSD.
module savestate_sequencer
  import savestate_pkg::*;
#(
  parameter int TIMEOUT_BITS = 24,
  parameter int SLOTS        = 4
) (
  input logic                  clk,
  input logic                  reset,
  savestate_sequencer_if.slave bus
);

  state_t                  state_q;
  pend_t                   pend_q;
  logic                    vblank_q;
  logic                    result_ok_q;
  logic [TIMEOUT_BITS-1:0] wd_q;
  logic                    pause_req_q;
  logic                    eng_start_q;
  logic                    eng_load_q;
  logic [1:0]              eng_slot_q;
  logic [SLOTS-1:0]        valid_q;
  logic                    info_req_q;
  logic [7:0]              info_q;

  pend_t req_d;
  pend_t sel_d;

  // Save wins a same-cycle collision; a fresh request beats an older pending one.
  always_comb begin
    req_d       = '0;
    req_d.valid = bus.req_save | bus.req_load;
    req_d.load  = bus.req_load & ~bus.req_save;
    req_d.slot  = bus.req_slot;
    sel_d       = req_d.valid ? req_d : pend_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      vblank_q    <= 1'b0;
      result_ok_q <= 1'b0;
      wd_q        <= '0;
      pause_req_q <= 1'b0;
      eng_start_q <= 1'b0;
      eng_load_q  <= 1'b0;
      eng_slot_q  <= '0;
      valid_q     <= '0;
      info_req_q  <= 1'b0;
      info_q      <= '0;
    end else begin
      vblank_q    <= bus.vblank;
      eng_start_q <= 1'b0;
      info_req_q  <= 1'b0;
      if (state_q != IDLE && req_d.valid) pend_q <= req_d;

      case (state_q)
        IDLE: begin
          if (sel_d.valid) begin
            eng_load_q <= sel_d.load;
            eng_slot_q <= sel_d.slot;
            pend_q     <= '0;
            if (sel_d.load && !valid_q[sel_d.slot]) begin
              info_q     <= INFO_EMPTY;
              info_req_q <= 1'b1;
              state_q    <= REPORT;
            end else begin
              state_q <= WAIT_SYNC;
            end
          end
        end
        WAIT_SYNC: begin
          if (bus.vblank && !vblank_q) begin
            pause_req_q <= 1'b1;
            state_q     <= PAUSE;
          end
        end
        PAUSE: begin
          if (bus.pause_ack) begin
            wd_q        <= '0;
            eng_start_q <= 1'b1;
            state_q     <= START;
          end
        end
        // The START cycle counts toward the watchdog, so RUN lasts 2**(TIMEOUT_BITS-1) cycles.
        START: begin
          wd_q    <= wd_q + {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};
          state_q <= RUN;
        end
        RUN: begin
          if (bus.eng_done) begin
            result_ok_q <= 1'b1;
            pause_req_q <= 1'b0;
            state_q     <= RESUME;
          end else if (wd_q[TIMEOUT_BITS-1]) begin
            result_ok_q <= 1'b0;
            pause_req_q <= 1'b0;
            state_q     <= RESUME;
          end else begin
            wd_q <= wd_q + {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};
          end
        end
        RESUME: begin
          if (!bus.pause_ack) begin
            info_q     <= result_ok_q ? ok_code(eng_slot_q, eng_load_q) : INFO_TIMEOUT;
            info_req_q <= 1'b1;
            if (!eng_load_q) valid_q[eng_slot_q] <= result_ok_q;
            state_q    <= REPORT;
          end
        end
        REPORT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (bus.init_stb) valid_q <= bus.slot_valid_init;
    end
  end

  assign bus.pause_req  = pause_req_q;
  assign bus.eng_start  = eng_start_q;
  assign bus.eng_load   = eng_load_q;
  assign bus.eng_slot   = eng_slot_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.slot_valid = valid_q;
  assign bus.info_req   = info_req_q;
  assign bus.info       = info_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_savestate_sequencer.sv
// Directed plus randomized bench for savestate_sequencer against a slot/result model.
module tb_savestate_sequencer;
  import savestate_pkg::*;

  localparam int TO_BITS   = 7;
  localparam int TO_CYCLES = 1 << (TO_BITS - 1);

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  int         cyc   = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         t_start;
  int         t_done;
  logic [7:0] exp_q[$];
  logic [3:0] model_valid = 4'b0000;

  savestate_sequencer_if #(.SLOTS(4)) bus ();

  savestate_sequencer #(.TIMEOUT_BITS(TO_BITS), .SLOTS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outcome of one operation from the slot rules; updates the slot model.
  function automatic logic [7:0] model_op(input bit ld, input int slot, input bit done);
    if (ld && !model_valid[slot]) return 8'd19;
    if (!done) begin
      if (!ld) model_valid[slot] = 1'b0;
      return 8'd18;
    end
    if (!ld) model_valid[slot] = 1'b1;
    return 8'(10 + 2 * slot + int'(ld));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_req(input bit s, input bit l, input logic [1:0] slot);
    bus.req_save = s;
    bus.req_load = l;
    bus.req_slot = slot;
    tick();
    bus.req_save = 1'b0;
    bus.req_load = 1'b0;
  endtask

  task automatic load_init(input logic [3:0] bits);
    bus.slot_valid_init = bits;
    bus.init_stb = 1'b1;
    tick();
    bus.init_stb = 1'b0;
    model_valid = bits;
    check("init_slot_valid", bus.slot_valid, bits);
  endtask

  task automatic report_empty();
    logic [7:0] e;
    check("empty_info_req", bus.info_req, 1);
    e = exp_q.pop_front();
    check("empty_info", bus.info, e);
    check("empty_no_pause", bus.pause_req, 0);
    tick();
    check("empty_info_req_lo", bus.info_req, 0);
    check("empty_busy", bus.busy, 0);
    check("empty_no_pause2", bus.pause_req, 0);
  endtask

  task automatic start_phase(input bit ld, input logic [1:0] slot, input int vbl,
                             input int ack, input bit early);
    repeat (vbl) tick();
    check("pause_before_edge", bus.pause_req, 0);
    bus.vblank = 1'b1;
    if (early) bus.pause_ack = 1'b1;
    tick();
    check("pause_req_latency", bus.pause_req, 1);
    check("busy_paused", bus.busy, 1);
    bus.vblank = 1'b0;
    if (!early) begin
      repeat (ack) tick();
      bus.pause_ack = 1'b1;
    end
    tick();
    check("eng_start_hi", bus.eng_start, 1);
    check("eng_load", bus.eng_load, ld);
    check("eng_slot", bus.eng_slot, slot);
    t_start = cyc;
    tick();
    check("eng_start_pulse", bus.eng_start, 0);
  endtask

  task automatic finish_phase(input bit done, input int d, input int rel);
    int k;
    logic [7:0] e;
    if (done) begin
      repeat (d) tick();
      bus.eng_done = 1'b1;
      t_done = cyc;
      tick();
      bus.eng_done = 1'b0;
    end
    k = 0;
    while (bus.pause_req !== 1'b0 && k < 4 * TO_CYCLES) begin
      tick();
      k++;
    end
    check("pause_drop", bus.pause_req, 0);
    check("run_len", cyc - t_start - 1, done ? t_done - t_start : TO_CYCLES);
    repeat (rel) tick();
    bus.pause_ack = 1'b0;
    tick();
    check("info_req_hi", bus.info_req, 1);
    e = exp_q.pop_front();
    check("info", bus.info, e);
    check("slot_valid", bus.slot_valid, model_valid);
    tick();
    check("info_req_lo", bus.info_req, 0);
    check("info_hold", bus.info, e);
    check("busy_idle", bus.busy, 0);
  endtask

  task automatic full_op(input bit ld, input bit both, input logic [1:0] slot, input bit done,
                         input int d, input int vbl, input int ack, input bit early, input int rel);
    logic [7:0] e;
    e = model_op(ld, int'(slot), done);
    exp_q.push_back(e);
    pulse_req(!ld, ld | both, slot);
    if (e == 8'd19) begin
      report_empty();
    end else begin
      check("busy_wait_sync", bus.busy, 1);
      start_phase(ld, slot, vbl, ack, early);
      finish_phase(done, d, rel);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_seen;
    bus.req_save = 1'b0;
    bus.req_load = 1'b0;
    bus.req_slot = 2'd0;
    bus.vblank = 1'b0;
    bus.pause_ack = 1'b0;
    bus.eng_done = 1'b0;
    bus.slot_valid_init = 4'b0000;
    bus.init_stb = 1'b0;

    repeat (2) tick();
    check("rst_pause_req", bus.pause_req, 0);
    check("rst_eng_start", bus.eng_start, 0);
    check("rst_eng_load", bus.eng_load, 0);
    check("rst_eng_slot", bus.eng_slot, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_slot_valid", bus.slot_valid, 0);
    check("rst_info_req", bus.info_req, 0);
    check("rst_info", bus.info, 0);
    reset = 1'b0;
    tick();

    // Save slot 2: vblank after 100 cycles, ack 3 after pause, done 50 after start.
    exp_q.push_back(model_op(1'b0, 2, 1'b1));
    pulse_req(1'b1, 1'b0, 2'd2);
    check("t1_busy", bus.busy, 1);
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    check("t1_stray_done", bus.pause_req, 0);
    start_phase(1'b0, 2'd2, 100, 3, 1'b0);
    bus.pause_ack = 1'b0;
    finish_phase(1'b1, 49, 0);
    check("t1_slot_valid", bus.slot_valid, 4'b0100);

    // Load from an empty slot: rejected without pausing the core.
    full_op(1'b1, 1'b0, 2'd1, 1'b1, 5, 1, 1, 1'b0, 1);

    // Save and load together on slot 1: save wins.
    full_op(1'b0, 1'b1, 2'd1, 1'b1, 10, 2, 1, 1'b0, 2);

    // Watchdog timeout on a save clears the slot.
    full_op(1'b0, 1'b0, 2'd2, 1'b0, 0, 1, 0, 1'b0, 1);
    check("t_timeout_valid", bus.slot_valid, 4'b0010);

    // Pending: load 0 then load 3 during a running save; only load 3 runs afterwards.
    load_init(4'b1010);
    exp_q.push_back(model_op(1'b0, 1, 1'b1));
    pulse_req(1'b1, 1'b0, 2'd1);
    start_phase(1'b0, 2'd1, 2, 0, 1'b1);
    pulse_req(1'b0, 1'b1, 2'd0);
    tick();
    pulse_req(1'b0, 1'b1, 2'd3);
    exp_q.push_back(model_op(1'b1, 3, 1'b1));
    finish_phase(1'b1, 5, 1);
    start_phase(1'b1, 2'd3, 2, 2, 1'b0);
    finish_phase(1'b1, 7, 0);
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.busy) busy_seen++;
    end
    check("pend_single_op", busy_seen, 0);

    // Randomized operations against the model.
    for (int n = 0; n < 16; n++) begin
      bit ld;
      bit both;
      if ($urandom_range(0, 3) == 0) load_init(4'($urandom_range(0, 15)));
      ld   = 1'($urandom_range(0, 1));
      both = !ld && ($urandom_range(0, 3) == 0);
      full_op(ld, both, 2'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
              $urandom_range(0, 40), $urandom_range(0, 5), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), $urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) tick();
    end

    // Asynchronous reset in RUN.
    pulse_req(1'b1, 1'b0, 2'd0);
    start_phase(1'b0, 2'd0, 1, 1, 1'b0);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    check("arst_pause_req", bus.pause_req, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_slot_valid", bus.slot_valid, 0);
    bus.pause_ack = 1'b0;
    exp_q.delete();
    model_valid = 4'b0000;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    full_op(1'b0, 1'b0, 2'd3, 1'b1, 4, 1, 1, 1'b0, 0);
    check("post_rst_valid", bus.slot_valid, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
